// File: rtl/tent_keystream_ctrl_if.sv
// tent_keystream_ctrl_if: bundles the request, tent-core and key-stream signals of the controller.
// Request side : start, seed, alpha_in, num_keys, burn_in (into the controller)
// Core side    : core_flag2, core_tent, core_alpha (out), core_key3, core_done3 (in)
// Key side     : key_out, key_valid (out), key_ready (in)
// Status       : busy, done, err (out)
// The slave modport is the controller's view; master is the environment's view.
interface tent_keystream_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] seed;
    logic [DATA_WIDTH-1:0] alpha_in;
    logic [CNT_WIDTH-1:0]  num_keys;
    logic [3:0]            burn_in;
    logic                  core_flag2;
    logic [DATA_WIDTH-1:0] core_tent;
    logic [DATA_WIDTH-1:0] core_alpha;
    logic [DATA_WIDTH-1:0] core_key3;
    logic                  core_done3;
    logic [DATA_WIDTH-1:0] key_out;
    logic                  key_valid;
    logic                  key_ready;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  start, seed, alpha_in, num_keys, burn_in, core_key3, core_done3, key_ready,
        output core_flag2, core_tent, core_alpha, key_out, key_valid, busy, done, err
    );

    modport master (
        output start, seed, alpha_in, num_keys, burn_in, core_key3, core_done3, key_ready,
        input  core_flag2, core_tent, core_alpha, key_out, key_valid, busy, done, err
    );
endinterface

// File: rtl/tent_keystream_ctrl.sv
// tent_keystream_ctrl: sequences an external tent-map core to produce a burn-in-skipped key stream.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - tent_keystream_ctrl_if.slave: run request, core handshake, key stream, status
// A run iterates the core (CLEAR, RUN until done3), discards burn_in results, then
// emits num_keys results through a valid/ready handshake and finishes with a done pulse.
module tent_keystream_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8,
    parameter int TIMEOUT    = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    tent_keystream_ctrl_if.slave bus
);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, EMIT, FIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic [DATA_WIDTH-1:0] alpha_q, alpha_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [CNT_WIDTH-1:0]  keys_q, keys_d;
    logic [3:0]            iter_q, iter_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            alpha_q <= '0;
            key_q   <= '0;
            keys_q  <= '0;
            iter_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            alpha_q <= alpha_d;
            key_q   <= key_d;
            keys_q  <= keys_d;
            iter_q  <= iter_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        alpha_d = alpha_q;
        key_d   = key_q;
        keys_d  = keys_q;
        iter_d  = iter_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.start) begin
                y_d     = bus.seed;
                alpha_d = bus.alpha_in;
                keys_d  = bus.num_keys;
                iter_d  = bus.burn_in;
                err_d   = (bus.alpha_in == '0);
                state_d = (bus.alpha_in == '0 || bus.num_keys == '0) ? FIN : CLEAR;
            end
            CLEAR: begin
                wait_d  = '0;
                state_d = RUN;
            end
            RUN: if (bus.core_done3) begin
                y_d = bus.core_key3;
                if (iter_q != 4'd0) begin
                    iter_d  = iter_q - 4'd1;
                    state_d = CLEAR;
                end else begin
                    key_d   = bus.core_key3;
                    state_d = EMIT;
                end
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = FIN;
            end else begin
                wait_d = wait_q + WW'(1);
            end
            // keys_q is never zero here: zero-key runs go straight to FIN.
            EMIT: if (bus.key_ready) begin
                keys_d  = keys_q - CNT_WIDTH'(1);
                state_d = (keys_q == CNT_WIDTH'(1)) ? FIN : CLEAR;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.core_flag2 = (state_q == RUN);
    assign bus.core_tent  = y_q;
    assign bus.core_alpha = alpha_q;
    assign bus.key_out    = key_q;
    assign bus.key_valid  = (state_q == EMIT);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == FIN);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_tent_keystream_ctrl.sv
// tb_tent_keystream_ctrl: directed runs of the key-stream controller against a tent-map core model and key scoreboard.
module tb_tent_keystream_ctrl;
    localparam int DW = 12;
    localparam int CW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tent_keystream_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

    tent_keystream_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] log_q[$];
    logic core_en = 1'b1;
    logic ph = 1'b0;

    function automatic logic [DW-1:0] tent(input logic [DW-1:0] x, input logic [DW-1:0] a);
        longint f, xv, av;
        f = longint'(1) << DW;
        xv = longint'(x);
        av = longint'(a);
        return (xv < av) ? DW'((xv * f) / av) : DW'(((f - xv) * f) / (f - av));
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Core model: latches its input on the first enabled cycle, answers on the next.
    always @(posedge clk) begin
        if (bus.core_flag2 !== 1'b1 || !core_en) begin
            ph <= 1'b0;
            bus.core_done3 <= 1'b0;
        end else if (!ph) begin
            ph <= 1'b1;
            bus.core_done3 <= 1'b1;
            bus.core_key3 <= tent(bus.core_tent, bus.core_alpha);
        end
    end

    // Key scoreboard and valid/data stability monitor.
    logic pv = 1'b0;
    logic [DW-1:0] pk = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
        end else begin
            if (pv) begin
                chk("valid_held", longint'(bus.key_valid), 1);
                chk("key_held", longint'(bus.key_out), longint'(pk));
            end
            if (bus.key_valid && bus.key_ready) begin
                log_q.push_back(bus.key_out);
                chk("key_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("key", longint'(bus.key_out), longint'(exp_q.pop_front()));
            end
            pv <= bus.key_valid && !bus.key_ready;
            pk <= bus.key_out;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_flag2"}, longint'(bus.core_flag2), 0);
        chk({tag, "_key_valid"}, longint'(bus.key_valid), 0);
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_done"}, longint'(bus.done), 0);
        chk({tag, "_err"}, longint'(bus.err), 0);
        chk({tag, "_core_tent"}, longint'(bus.core_tent), 0);
        chk({tag, "_core_alpha"}, longint'(bus.core_alpha), 0);
        chk({tag, "_key_out"}, longint'(bus.key_out), 0);
    endtask

    task automatic load_exp(input logic [DW-1:0] s, input logic [DW-1:0] a, input int n, input int b);
        logic [DW-1:0] y;
        y = s;
        exp_q.delete();
        log_q.delete();
        if (a != '0 && core_en)
            for (int i = 0; i < b + n; i++) begin
                y = tent(y, a);
                if (i >= b) exp_q.push_back(y);
            end
    endtask

    // Called at posedge+1; rmode 1: ready high, 2: fixed pattern, 3: low for 10 EMIT cycles.
    task automatic run(input logic [DW-1:0] s, input logic [DW-1:0] a, input logic [CW-1:0] n,
                       input logic [3:0] b, input int rmode, input logic e_err, input int e_busy,
                       input int e_fl, input bit mid_start);
        int busy_n, fl_n, cyc, emit_n;
        bit got_done;
        logic err_v;
        busy_n = 0; fl_n = 0; cyc = 0; emit_n = 0; got_done = 0; err_v = 1'b0;
        load_exp(s, a, int'(n), int'(b));
        bus.seed = s;
        bus.alpha_in = a;
        bus.num_keys = n;
        bus.burn_in = b;
        bus.start = 1'b1;
        bus.key_ready = (rmode == 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (!got_done && cyc < 500) begin
            @(negedge clk);
            if (cyc == 0) chk("err_on_accept", longint'(bus.err), longint'(a == '0));
            busy_n += int'(bus.busy);
            fl_n += int'(bus.core_flag2);
            emit_n += int'(bus.key_valid);
            if (bus.busy) chk("core_alpha", longint'(bus.core_alpha), longint'(a));
            got_done = bus.done;
            err_v = bus.err;
            cyc++;
            @(posedge clk);
            #1;
            bus.key_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? (cyc % 3 != 0) : (emit_n >= 10);
            if (mid_start) begin
                bus.start = (cyc == 3);
                if (cyc == 3) begin
                    bus.seed = '1;
                    bus.alpha_in = '0;
                    bus.num_keys = '0;
                    bus.burn_in = 4'hF;
                end
            end
        end
        bus.start = 1'b0;
        chk("done_seen", longint'(got_done), 1);
        chk("err_at_done", longint'(err_v), longint'(e_err));
        chk("keys_left", longint'(exp_q.size()), 0);
        if (e_busy >= 0) chk("busy_cycles", longint'(busy_n), longint'(e_busy));
        if (e_fl >= 0) chk("flag2_cycles", longint'(fl_n), longint'(e_fl));
    endtask

    task automatic reset_mid();
        int c;
        c = 0;
        load_exp(12'h200, 12'h800, 3, 0);
        bus.seed = 12'h200;
        bus.alpha_in = 12'h800;
        bus.num_keys = 8'd3;
        bus.burn_in = 4'd0;
        bus.key_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (c < 200 && !(log_q.size() >= 1 && bus.core_flag2 && !bus.core_done3)) begin
            @(negedge clk);
            c++;
        end
        chk("reached_second_run", longint'(c < 200), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.seed = '0;
        bus.alpha_in = '0;
        bus.num_keys = '0;
        bus.burn_in = '0;
        bus.key_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        chk("tent_0x200", longint'(tent(12'h200, 12'h800)), 'h400);
        chk("tent_0x400", longint'(tent(12'h400, 12'h800)), 'h800);
        chk("tent_0x800", longint'(tent(12'h800, 12'h800)), 'h000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(12'h200, 12'h800, 8'd3, 4'd0, 1, 1'b0, 13, 6, 1'b0);
        chk("basic_n", longint'(log_q.size()), 3);
        if (log_q.size() == 3) begin
            chk("basic_k0", longint'(log_q[0]), 'h400);
            chk("basic_k1", longint'(log_q[1]), 'h800);
            chk("basic_k2", longint'(log_q[2]), 'h000);
        end
        run(12'h200, 12'h800, 8'd1, 4'd2, 1, 1'b0, 11, 6, 1'b0);
        chk("burn_n", longint'(log_q.size()), 1);
        if (log_q.size() == 1) chk("burn_k0", longint'(log_q[0]), 'h000);
        run(12'h200, 12'h800, 8'd1, 4'd0, 3, 1'b0, 15, 2, 1'b0);
        if (log_q.size() == 1) chk("stall_k0", longint'(log_q[0]), 'h400);
        run(12'h123, 12'h000, 8'd5, 4'd0, 1, 1'b1, 1, 0, 1'b0);
        chk("err_sticky", longint'(bus.err), 1);
        run(12'h200, 12'h800, 8'd2, 4'd0, 1, 1'b0, 9, 4, 1'b0);
        core_en = 1'b0;
        run(12'h200, 12'h800, 8'd2, 4'd0, 1, 1'b1, 2 + TO, TO, 1'b0);
        core_en = 1'b1;
        run(12'h200, 12'h800, 8'd0, 4'd3, 1, 1'b0, 1, 0, 1'b0);
        run(12'h5A5, 12'h600, 8'd6, 4'd1, 2, 1'b0, -1, 14, 1'b1);
        chk("mixed_n", longint'(log_q.size()), 6);
        reset_mid();
        run(12'h200, 12'h800, 8'd3, 4'd0, 1, 1'b0, 13, 6, 1'b0);
        chk("after_reset_n", longint'(log_q.size()), 3);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
